// File: rtl/button_debouncer_pkg.sv
// Shared definitions for the button debouncer: per-channel state encoding,
// counter width and the acceptance limit helper.
package button_debouncer_pkg;

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    S_LOW  = 2'd0,
    S_RISE = 2'd1,
    S_HIGH = 2'd2,
    S_FALL = 2'd3
  } db_state_t;

  // Number of identical samples needed, sized to the counter.
  function automatic logic [CNT_W-1:0] stable_limit(input int samples);
    return CNT_W'(samples);
  endfunction

endpackage

// File: rtl/button_debouncer_channel.sv
// One debounced button: input synchronizer, tick-driven FSM with a run counter,
// and registered level / press / release outputs.
module debounce_channel
  import button_debouncer_pkg::*;
#(
  parameter int STABLE_SAMPLES = 3
) (
  input  logic CLK,
  input  logic RESET,
  input  logic tick,
  input  logic btn_raw,
  output logic level,
  output logic press,
  output logic released
);

  localparam logic [CNT_W-1:0] LIMIT = stable_limit(STABLE_SAMPLES);

  logic [1:0]       btn_sync;
  logic             sample;
  db_state_t        state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;

  assign sample  = btn_sync[1];
  assign cnt_nxt = cnt + CNT_W'(1);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) btn_sync <= '0;
    else       btn_sync <= {btn_sync[0], btn_raw};
  end

  // Pulses default low every cycle; only a completed run sets them.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state    <= S_LOW;
      cnt      <= '0;
      level    <= 1'b0;
      press    <= 1'b0;
      released <= 1'b0;
    end else begin
      press    <= 1'b0;
      released <= 1'b0;
      if (tick) begin
        case (state)
          S_LOW: begin
            if (sample) begin
              state <= S_RISE;
              cnt   <= CNT_W'(1);
            end
          end
          S_RISE: begin
            if (!sample) begin
              state <= S_LOW;
              cnt   <= '0;
            end else if (cnt_nxt == LIMIT) begin
              state <= S_HIGH;
              cnt   <= '0;
              level <= 1'b1;
              press <= 1'b1;
            end else begin
              cnt <= cnt_nxt;
            end
          end
          S_HIGH: begin
            if (!sample) begin
              state <= S_FALL;
              cnt   <= CNT_W'(1);
            end
          end
          S_FALL: begin
            if (sample) begin
              state <= S_HIGH;
              cnt   <= '0;
            end else if (cnt_nxt == LIMIT) begin
              state    <= S_LOW;
              cnt      <= '0;
              level    <= 1'b0;
              released <= 1'b1;
            end else begin
              cnt <= cnt_nxt;
            end
          end
          default: begin
            state <= S_LOW;
            cnt   <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/button_debouncer.sv
// N-channel button debouncer. SLOW_CLK is treated as data: synchronized and
// rising-edge detected into a one-CLK sample tick shared by all channels.
module button_debouncer
  import button_debouncer_pkg::*;
#(
  parameter int N_BTN          = 4,
  parameter int STABLE_SAMPLES = 3
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             SLOW_CLK,
  input  logic [N_BTN-1:0] BTN_IN,
  output logic [N_BTN-1:0] BTN_LEVEL,
  output logic [N_BTN-1:0] BTN_PRESS,
  output logic [N_BTN-1:0] BTN_RELEASE
);

  logic [1:0] slow_sync;
  logic       slow_prev;
  logic       tick;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      slow_sync <= '0;
      slow_prev <= 1'b0;
    end else begin
      slow_sync <= {slow_sync[0], SLOW_CLK};
      slow_prev <= slow_sync[1];
    end
  end

  // Consumed by the channels on the third CLK edge after SLOW_CLK rises.
  assign tick = slow_sync[1] & ~slow_prev;

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    debounce_channel #(
      .STABLE_SAMPLES(STABLE_SAMPLES)
    ) u_ch (
      .CLK      (CLK),
      .RESET    (RESET),
      .tick     (tick),
      .btn_raw  (BTN_IN[i]),
      .level    (BTN_LEVEL[i]),
      .press    (BTN_PRESS[i]),
      .released (BTN_RELEASE[i])
    );
  end

endmodule

// File: tb/tb_button_debouncer.sv
// Directed + random bench for button_debouncer against a run-length model.
module tb_button_debouncer;

  localparam int N      = 4;
  localparam int STABLE = 3;
  localparam int SLOW_P = 20;

  logic         CLK = 1'b0;
  logic         RESET = 1'b1;
  logic         SLOW_CLK = 1'b0;
  logic [N-1:0] BTN_IN = '0;
  logic [N-1:0] BTN_LEVEL, BTN_PRESS, BTN_RELEASE;

  button_debouncer #(.N_BTN(N), .STABLE_SAMPLES(STABLE)) dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .SLOW_CLK    (SLOW_CLK),
    .BTN_IN      (BTN_IN),
    .BTN_LEVEL   (BTN_LEVEL),
    .BTN_PRESS   (BTN_PRESS),
    .BTN_RELEASE (BTN_RELEASE)
  );

  always #5 CLK = ~CLK;

  // Reference model: a tick is seen when SLOW_CLK observed two edges ago is
  // high and three edges ago low; the button value used is the one observed
  // two edges ago. A level flips after STABLE consecutive disagreeing samples.
  logic [2:0]   sh;
  logic [N-1:0] bh0, bh1;
  logic [N-1:0] m_level, m_press, m_rel;
  int           m_run [N];

  always @(posedge CLK or posedge RESET) begin
    automatic logic [N-1:0] lv;
    automatic logic [N-1:0] pr;
    automatic logic [N-1:0] rl;
    automatic logic         tk;
    if (RESET) begin
      sh      <= '0;
      bh0     <= '0;
      bh1     <= '0;
      m_level <= '0;
      m_press <= '0;
      m_rel   <= '0;
      for (int i = 0; i < N; i++) m_run[i] <= 0;
    end else begin
      tk = sh[1] & ~sh[2];
      lv = m_level;
      pr = '0;
      rl = '0;
      if (tk) begin
        for (int i = 0; i < N; i++) begin
          if (bh1[i] != lv[i]) begin
            if (m_run[i] + 1 == STABLE) begin
              lv[i] = bh1[i];
              if (bh1[i]) pr[i] = 1'b1;
              else        rl[i] = 1'b1;
              m_run[i] <= 0;
            end else begin
              m_run[i] <= m_run[i] + 1;
            end
          end else begin
            m_run[i] <= 0;
          end
        end
      end
      m_level <= lv;
      m_press <= pr;
      m_rel   <= rl;
      sh      <= {sh[1:0], SLOW_CLK};
      bh1     <= bh0;
      bh0     <= BTN_IN;
    end
  end

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int pcnt [N];
  int rcnt [N];
  int hits     = 0;
  logic [N-1:0] pat = '0;

  task automatic check(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs == exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic clear_tally();
    for (int i = 0; i < N; i++) begin
      pcnt[i] = 0;
      rcnt[i] = 0;
    end
    hits = 0;
  endtask

  // One CLK: check outputs at the falling edge, tally pulses, advance SLOW_CLK.
  task automatic step();
    @(negedge CLK);
    check("level", BTN_LEVEL, m_level);
    check("press", BTN_PRESS, m_press);
    check("release", BTN_RELEASE, m_rel);
    for (int i = 0; i < N; i++) begin
      pcnt[i] += int'(BTN_PRESS[i]);
      rcnt[i] += int'(BTN_RELEASE[i]);
    end
    if (pat != '0 && BTN_PRESS === pat) hits++;
    cyc++;
    SLOW_CLK = (cyc % SLOW_P) < (SLOW_P / 2);
  endtask

  task automatic steps(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  initial begin
    int w;
    clear_tally();

    // Reset held with all buttons pressed: everything stays cleared.
    BTN_IN = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      step();
      check("rst_level", BTN_LEVEL, 4'b0000);
      check("rst_press", BTN_PRESS, 4'b0000);
    end
    pat = 4'b1111;
    RESET = 1'b0;
    steps(80);
    check_int("all_press_once", hits, 1);
    check("all_level", BTN_LEVEL, 4'b1111);

    BTN_IN = 4'b0000;
    steps(80);
    check("all_released", BTN_LEVEL, 4'b0000);

    // Clean press on bit 0.
    clear_tally();
    BTN_IN = 4'b0001;
    steps(100);
    check_int("b0_press_cnt", pcnt[0], 1);
    check("b0_level", BTN_LEVEL, 4'b0001);

    // Bit 1 high for exactly two sample points: must be rejected.
    clear_tally();
    BTN_IN = 4'b0011;
    steps(2 * SLOW_P);
    BTN_IN = 4'b0001;
    steps(60);
    check_int("glitch_press", pcnt[1], 0);
    check_int("glitch_release", rcnt[1], 0);
    check("glitch_level", BTN_LEVEL, 4'b0001);

    // Bouncy release on bit 2.
    BTN_IN = 4'b0101;
    steps(80);
    clear_tally();
    for (int k = 0; k < 5; k++) begin
      BTN_IN[2] = ~BTN_IN[2];
      steps(3);
    end
    BTN_IN[2] = 1'b0;
    steps(80);
    check_int("bounce_release", rcnt[2], 1);
    check_int("bounce_press", pcnt[2], 0);

    // Simultaneous press on bits 0 and 3.
    BTN_IN = 4'b0000;
    steps(80);
    clear_tally();
    pat = 4'b1001;
    BTN_IN = 4'b1001;
    steps(80);
    check_int("simul_press", hits, 1);
    check("simul_level", BTN_LEVEL, 4'b1001);

    // Asynchronous reset while bit 0 is two samples into a press.
    BTN_IN = 4'b1000;
    steps(80);
    BTN_IN = 4'b1001;
    w = 0;
    while (m_run[0] != 2 && w < 200) begin
      step();
      w++;
    end
    check_int("wait_run2_timeout", int'(w < 200), 1);
    #2 RESET = 1'b1;
    #1;
    check("async_level", BTN_LEVEL, 4'b0000);
    check("async_press", BTN_PRESS, 4'b0000);
    check("async_release", BTN_RELEASE, 4'b0000);
    steps(3);
    RESET = 1'b0;
    steps(30);
    check("fresh_count", BTN_LEVEL & 4'b0001, 4'b0000);
    steps(80);
    check("post_rst_level", BTN_LEVEL, 4'b1001);

    // Random toggling, including short bursts.
    pat = '0;
    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(29, 0) == 0) BTN_IN[$urandom_range(N-1, 0)] ^= 1'b1;
      step();
    end
    BTN_IN = '0;
    steps(80);
    check("final_level", BTN_LEVEL, 4'b0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
